// File: rtl/makeshift_rr_resp_router.sv
// makeshift_rr_resp_router
//
// Return path for the two-input round-robin request arbiter. Each issued grant
// records its source id (0 or 1) in a small in-order tag FIFO; responses coming
// back from the downstream responder are steered to the requester at the FIFO
// head through a valid/ready handshake. The arbiter is back-pressured through
// ready_o when the tag FIFO is full.
//
// Ports:
//   clk_i          sole clock, all state updates on posedge
//   reset_i        synchronous, active-high reset
//   grants_i       one-hot grant pulse from the arbiter (bit i = source i issued)
//   ready_o        tag space available; arbiter yumi must be gated with this
//   resp_v_i       downstream response valid
//   resp_data_i    downstream response payload
//   resp_ready_o   response accepted this cycle when high together with resp_v_i
//   resp_v_o       per-requester response valid, at most one bit high
//   resp_data_o    response payload shared by both requesters
//   resp_ready_i   per-requester ready
//   outstanding_o  number of granted requests still awaiting a response
//   error_o        sticky protocol-violation flag, cleared only by reset

module makeshift_rr_resp_router #(
  parameter int unsigned data_width_p = 32,
  parameter int unsigned els_p        = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [1:0]                   grants_i,
  output logic                         ready_o,
  input  logic                         resp_v_i,
  input  logic [data_width_p-1:0]      resp_data_i,
  output logic                         resp_ready_o,
  output logic [1:0]                   resp_v_o,
  output logic [data_width_p-1:0]      resp_data_o,
  input  logic [1:0]                   resp_ready_i,
  output logic [$clog2(els_p+1)-1:0]   outstanding_o,
  output logic                         error_o
);

  localparam int unsigned PtrW = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int unsigned CntW = $clog2(els_p + 1);

  // Tag storage: one bit per entry holding the source id of the grant.
  logic [els_p-1:0] r_tags;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [PtrW-1:0]  r_wr_ptr;
  logic [CntW-1:0]  r_count;
  logic             r_error;

  logic            w_empty;
  logic            w_full;
  logic            w_head_id;
  logic            w_single_grant;
  logic            w_push;
  logic            w_pop;
  logic            w_resp_ready;
  logic            w_err;
  logic [CntW-1:0] w_count_next;

  // Circular pointer advance; els_p need not be a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_empty        = (r_count == '0);
    w_full         = (r_count == CntW'(els_p));
    w_head_id      = r_tags[r_rd_ptr];
    w_single_grant = (grants_i == 2'b01) || (grants_i == 2'b10);

    // Push only for a legal one-hot grant with space; ready_o is purely registered
    // state, so a pop in the full cycle does not open space until the next cycle.
    w_push = w_single_grant && !w_full;

    // Head tag is only meaningful when not empty; a tag written this cycle is
    // not visible until next cycle (no bypass).
    w_resp_ready = !w_empty && resp_ready_i[w_head_id];
    w_pop        = resp_v_i && w_resp_ready;

    // Each violating action is dropped by the push/pop gating above.
    w_err = (grants_i == 2'b11)
         || ((grants_i != 2'b00) && w_full)
         || (resp_v_i && w_empty);

    unique case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  // Steering outputs.
  always_comb begin
    resp_v_o = 2'b00;
    if (resp_v_i && !w_empty) begin
      resp_v_o[w_head_id] = 1'b1;
    end
    resp_ready_o  = w_resp_ready;
    resp_data_o   = resp_data_i;
    ready_o       = !w_full;
    outstanding_o = r_count;
    error_o       = r_error;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_error  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      r_count <= w_count_next;
      if (w_err) begin
        r_error <= 1'b1;
      end
    end
  end

  // Tag contents need no reset; only entries behind the pointers are ever read.
  always_ff @(posedge clk_i) begin
    if (!reset_i && w_push) begin
      r_tags[r_wr_ptr] <= grants_i[1];
    end
  end

endmodule

// File: tb/tb_makeshift_rr_resp_router.sv
// Bench for makeshift_rr_resp_router: directed stimulus with hand-computed
// expectations. Accepted response beats are checked by a monitor against a
// queue of expected {resp_v_o, data}; status outputs are checked inline.

module tb_makeshift_rr_resp_router;

  localparam int unsigned DW  = 32;
  localparam int unsigned ELS = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    grants;
  logic          ready_o;
  logic          resp_v;
  logic [DW-1:0] resp_data;
  logic          resp_ready_o;
  logic [1:0]    resp_v_o;
  logic [DW-1:0] resp_data_o;
  logic [1:0]    resp_ready;
  logic [2:0]    outstanding_o;
  logic          error_o;

  makeshift_rr_resp_router #(
    .data_width_p(DW),
    .els_p       (ELS)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .grants_i     (grants),
    .ready_o      (ready_o),
    .resp_v_i     (resp_v),
    .resp_data_i  (resp_data),
    .resp_ready_o (resp_ready_o),
    .resp_v_o     (resp_v_o),
    .resp_data_o  (resp_data_o),
    .resp_ready_i (resp_ready),
    .outstanding_o(outstanding_o),
    .error_o      (error_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    v;
    logic [DW-1:0] d;
  } beat_t;

  beat_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] g, input logic v, input logic [DW-1:0] d,
                       input logic [1:0] rdy);
    grants     = g;
    resp_v     = v;
    resp_data  = d;
    resp_ready = rdy;
    #1;
  endtask

  task automatic idle();
    drive(2'b00, 1'b0, '0, 2'b00);
  endtask

  // One accepted response beat expected at requester one-hot 'id'.
  task automatic resp(input logic [1:0] id, input logic [DW-1:0] d);
    drive(2'b00, 1'b1, d, 2'b11);
    exp_q.push_back(beat_t'{v: id, d: d});
    tick();
  endtask

  task automatic grant(input logic [1:0] g);
    drive(g, 1'b0, '0, 2'b00);
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
  endtask

  // Monitor: every accepted beat must match the head of the expectation queue.
  task automatic monitor();
    beat_t e;
    forever begin
      @(negedge clk);
      if (!reset && resp_v && resp_ready_o) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat at %0t: got v=%b data=%0h, expected none",
                   $time, resp_v_o, resp_data_o);
        end else begin
          e = exp_q.pop_front();
          chk("beat_v", 32'(resp_v_o), 32'(e.v));
          chk("beat_data", resp_data_o, e.d);
        end
      end
    end
  endtask

  logic [1:0] ord [4];

  initial begin
    reset = 1'b1;
    idle();
    fork
      monitor();
    join_none

    // Reset state.
    tick();
    tick();
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_resp_v_o", 32'(resp_v_o), 32'd0);
    chk("rst_resp_ready", 32'(resp_ready_o), 32'd0);
    chk("rst_outstanding", 32'(outstanding_o), 32'd0);
    chk("rst_error", 32'(error_o), 32'd0);
    reset = 1'b0;
    idle();
    tick();
    chk("post_rst_outstanding", 32'(outstanding_o), 32'd0);
    chk("post_rst_ready", 32'(ready_o), 32'd1);

    // Ordering: 01, 10, 10, 01 then four responses.
    ord = '{2'b01, 2'b10, 2'b10, 2'b01};
    for (int i = 0; i < 4; i++) begin
      grant(ord[i]);
      chk("order_occ_up", 32'(outstanding_o), 32'(i + 1));
    end
    chk("order_full_ready", 32'(ready_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      resp(ord[i], 32'hA000_0000 + 32'(i));
      chk("order_occ_down", 32'(outstanding_o), 32'(3 - i));
    end
    idle();

    // Full: four grants fill, fifth is a protocol error.
    for (int i = 0; i < 4; i++) begin
      grant(i[0] ? 2'b10 : 2'b01);
    end
    chk("full_ready", 32'(ready_o), 32'd0);
    chk("full_occ", 32'(outstanding_o), 32'd4);
    chk("full_error_before", 32'(error_o), 32'd0);
    grant(2'b01);
    chk("full_error", 32'(error_o), 32'd1);
    chk("full_occ_after", 32'(outstanding_o), 32'd4);
    for (int i = 0; i < 4; i++) begin
      resp(i[0] ? 2'b10 : 2'b01, 32'hF000_0000 + 32'(i));
    end
    chk("drain_occ", 32'(outstanding_o), 32'd0);

    // Wrap: alternating grant/response pairs.
    for (int i = 0; i < 8; i++) begin
      grant(i[0] ? 2'b10 : 2'b01);
      resp(i[0] ? 2'b10 : 2'b01, 32'h1000_0000 + 32'(i));
      chk("wrap_occ", 32'(outstanding_o), 32'd0);
    end
    idle();
    chk("error_sticky", 32'(error_o), 32'd1);
    do_reset();
    chk("reset_clears_error", 32'(error_o), 32'd0);

    // Back-pressure: head = 1, ready only on requester 0 for three cycles.
    grant(2'b10);
    for (int k = 0; k < 3; k++) begin
      drive(2'b00, 1'b1, 32'hB000_00B0, 2'b01);
      chk("bp_resp_ready_low", 32'(resp_ready_o), 32'd0);
      chk("bp_resp_v_o", 32'(resp_v_o), 32'd2);
      tick();
    end
    drive(2'b00, 1'b1, 32'hB000_00B0, 2'b10);
    chk("bp_resp_ready_high", 32'(resp_ready_o), 32'd1);
    chk("bp_resp_v_o_final", 32'(resp_v_o), 32'd2);
    exp_q.push_back(beat_t'{v: 2'b10, d: 32'hB000_00B0});
    tick();
    idle();
    chk("bp_occ", 32'(outstanding_o), 32'd0);

    // Simultaneous push and pop at occupancy 2.
    grant(2'b10);
    grant(2'b01);
    chk("sim_occ_before", 32'(outstanding_o), 32'd2);
    drive(2'b01, 1'b1, 32'hC000_0000, 2'b11);
    exp_q.push_back(beat_t'{v: 2'b10, d: 32'hC000_0000});
    tick();
    chk("sim_occ_after", 32'(outstanding_o), 32'd2);
    drive(2'b00, 1'b1, 32'hC000_0001, 2'b11);
    chk("sim_head_adv", 32'(resp_v_o), 32'd1);
    exp_q.push_back(beat_t'{v: 2'b01, d: 32'hC000_0001});
    tick();
    resp(2'b01, 32'hC000_0002);
    idle();
    chk("sim_occ_end", 32'(outstanding_o), 32'd0);
    chk("sim_no_error", 32'(error_o), 32'd0);

    // Error: both grant bits.
    grant(2'b11);
    chk("err_grant11", 32'(error_o), 32'd1);
    chk("err_grant11_occ", 32'(outstanding_o), 32'd0);
    do_reset();
    chk("err_reset1", 32'(error_o), 32'd0);

    // Error: response while empty.
    drive(2'b00, 1'b1, 32'hE000_0000, 2'b11);
    chk("err_empty_resp_ready", 32'(resp_ready_o), 32'd0);
    chk("err_empty_resp_v_o", 32'(resp_v_o), 32'd0);
    tick();
    idle();
    chk("err_empty_error", 32'(error_o), 32'd1);
    chk("err_empty_occ", 32'(outstanding_o), 32'd0);
    do_reset();
    chk("err_reset2", 32'(error_o), 32'd0);

    // Empty boundary: push plus response in the same cycle, no bypass.
    drive(2'b01, 1'b1, 32'hE000_0001, 2'b11);
    chk("nobypass_resp_ready", 32'(resp_ready_o), 32'd0);
    tick();
    idle();
    chk("nobypass_occ", 32'(outstanding_o), 32'd1);
    chk("nobypass_error", 32'(error_o), 32'd1);
    do_reset();

    // Mid-operation reset with three outstanding.
    grant(2'b01);
    grant(2'b10);
    grant(2'b01);
    chk("mid_occ", 32'(outstanding_o), 32'd3);
    do_reset();
    chk("mid_rst_occ", 32'(outstanding_o), 32'd0);
    chk("mid_rst_ready", 32'(ready_o), 32'd1);
    drive(2'b00, 1'b1, 32'hD000_0000, 2'b11);
    chk("mid_rst_resp_ready", 32'(resp_ready_o), 32'd0);
    chk("mid_rst_resp_v_o", 32'(resp_v_o), 32'd0);
    tick();
    idle();
    tick();
    tick();

    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL beats_outstanding: got %0d unconsumed, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/makeshift_rr_resp_router.md
# makeshift_rr_resp_router

Return-path companion to the two-input round-robin request arbiter in the vanilla core. It records, in issue order, which of the two requesters won each arbitration and then steers the in-order response stream back to that requester through a valid/ready handshake. The block sits between the downstream responder and the two upstream requesters. It also back-pressures the arbiter when its tag FIFO is full.

## Interface
- data_width_p, 32: response payload width.
- els_p, 4: maximum outstanding granted requests (tag FIFO depth), ≥2, any integer.
- clk_i  in  1  sole clock; all state updates on posedge.
- reset_i  in  1  synchronous, active-high reset.
- grants_i  in  2  one-hot grant pulse from the arbiter: bit i = request from source i issued downstream this cycle; 2'b00 = no issue.
- ready_o  out  1  tag space available; the arbiter's yumi must be gated with this.
- resp_v_i  in  1  downstream response valid.
- resp_data_i  in  data_width_p  downstream response payload.
- resp_ready_o  out  1  response accepted this cycle when high with resp_v_i.
- resp_v_o  out  2  per-requester response valid; at most one bit high.
- resp_data_o  out  data_width_p  response payload, shared by both requesters.
- resp_ready_i  in  2  per-requester ready.
- outstanding_o  out  $clog2(els_p+1)  count of granted requests with no response yet.
- error_o  out  1  sticky protocol-violation flag.

## Operation
- Tag FIFO: els_p entries × 1 bit (source id), circular read/write pointers that wrap from els_p-1 to 0, plus an occupancy counter of width $clog2(els_p+1).
- Push: grants_i == 2'b01 pushes 0; grants_i == 2'b10 pushes 1. Push is legal only when ready_o = 1.
- Head: head_id = FIFO[rd_ptr], valid only when not empty.
- Steering (combinational):
  - resp_v_o[head_id] = resp_v_i & ~empty; the other bit is 0.
  - resp_data_o = resp_data_i, passed through unconditionally.
  - resp_ready_o = ~empty & resp_ready_i[head_id].
- Pop: occurs on resp_v_i & resp_ready_o; rd_ptr advances.
- Counter on simultaneous push and pop: occupancy unchanged, both pointers advance.
- ready_o = (occupancy != els_p), computed from registered state only.
- outstanding_o = occupancy.
- Protocol errors set error_o, which holds until reset. In each case the offending action is ignored and no state changes:
  - grants_i == 2'b11.
  - Nonzero grants_i while ready_o = 0.
  - resp_v_i high while empty. resp_ready_o stays 0 in this case.
- No bypass: a tag pushed in cycle N can steer a response no earlier than cycle N+1.
- Reset: pointers = 0, occupancy = 0, error_o = 0. FIFO contents are don't-care.

## Timing
- Response path is zero-latency, combinational from resp_v_i/resp_ready_i to resp_v_o/resp_ready_o.
- Tag capture: one cycle from grant to the tag becoming visible at the head.
- Outputs during and immediately after reset:
  - ready_o = 1.
  - resp_v_o = 2'b00.
  - resp_ready_o = 0.
  - outstanding_o = 0.
  - error_o = 0.
- Full boundary: at occupancy els_p, ready_o = 0. A pop in that cycle does not re-enable push until the next cycle.
- Empty boundary: with occupancy 0, a push plus resp_v_i in the same cycle produces no pop, and error_o is set.
- Reset asserted mid-operation discards all outstanding tags. Responses still in flight after reset are protocol errors.
- resp_v_i may be held high while resp_ready_i[head_id] is low. The response stays steered to the same requester until accepted.

## Test plan
- Ordering: grants 01, 10, 10, 01 on consecutive cycles, then four responses with both readies high.
  - Required: resp_v_o = 01, 10, 10, 01 in order, with data matched to each beat.
  - Required: outstanding_o steps 1,2,3,4 then back down to 0.
- Full/wrap (els_p=4): five grants back-to-back.
  - Required: ready_o drops after the 4th grant. The 5th grant sets error_o with outstanding_o = 4.
  - Then 8 alternating grant/response pairs exercise pointer wrap; steering must stay correct.
- Back-pressure: tag at head = 1, resp_v_i = 1, resp_ready_i = 2'b01 for 3 cycles, then 2'b10.
  - Required: resp_ready_o = 0 for 3 cycles, then 1. resp_v_o = 10 throughout.
- Simultaneous push/pop at occupancy 2: grant 01 together with an accepted response.
  - Required: outstanding_o stays 2 and head advances to the next tag.
- Errors:
  - grants_i = 11 → error_o = 1 next cycle, occupancy unchanged.
  - resp_v_i = 1 when empty → resp_ready_o = 0 and error_o = 1.
  - Reset → error_o = 0.
- Mid-operation reset with 3 outstanding: outstanding_o = 0 and ready_o = 1 on the cycle after reset.
